// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/arithmetic shift, parallel load, clear,
// registered serial output and a frame counter pulsing every WIDTH shifts.
module univ_shift_reg #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ASR   = 3'b101;
    localparam logic [2:0] MODE_LOAD  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] data_nxt;
    logic             ser_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             frame_nxt;
    logic             is_shift;
    logic             wrap;

    // Next-state datapath; en=0 falls through to the hold defaults
    always_comb begin
        data_nxt  = data_out;
        ser_nxt   = ser_out;
        cnt_nxt   = bit_cnt;
        frame_nxt = 1'b0;
        is_shift  = 1'b0;
        wrap      = (bit_cnt == CNT_LAST);
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                end
                MODE_SHL: begin
                    data_nxt = {data_out[WIDTH-2:0], ser_in_l};
                    ser_nxt  = data_out[WIDTH-1];
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    data_nxt = {ser_in_r, data_out[WIDTH-1:1]};
                    ser_nxt  = data_out[0];
                    is_shift = 1'b1;
                end
                MODE_ROL: begin
                    data_nxt = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                    ser_nxt  = data_out[WIDTH-1];
                    is_shift = 1'b1;
                end
                MODE_ROR: begin
                    data_nxt = {data_out[0], data_out[WIDTH-1:1]};
                    ser_nxt  = data_out[0];
                    is_shift = 1'b1;
                end
                MODE_ASR: begin
                    data_nxt = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
                    ser_nxt  = data_out[0];
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    data_nxt = load_data;
                    cnt_nxt  = '0;
                end
                MODE_CLEAR: begin
                    data_nxt = '0;
                    ser_nxt  = 1'b0;
                    cnt_nxt  = '0;
                end
                default: begin
                end
            endcase
            // Counter wraps at WIDTH-1 explicitly so non-power-of-two widths frame correctly
            if (is_shift) begin
                if (wrap) begin
                    cnt_nxt   = '0;
                    frame_nxt = 1'b1;
                end else begin
                    cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_out   <= '0;
            ser_out    <= 1'b0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= data_nxt;
            ser_out    <= ser_nxt;
            bit_cnt    <= cnt_nxt;
            frame_done <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4 and WIDTH=8.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn4, en4, sl4, sr4;
    logic [2:0] mode4;
    logic [3:0] ld4, d4;
    logic       so4, fd4;
    logic [1:0] cnt4;

    logic       rstn8, en8, sl8, sr8;
    logic [2:0] mode8;
    logic [7:0] ld8, d8;
    logic       so8, fd8;
    logic [2:0] cnt8;

    int n_cmp = 0;
    int n_err = 0;

    univ_shift_reg #(.WIDTH(4)) u4 (
        .clk(clk), .rstn(rstn4), .en(en4), .mode(mode4),
        .ser_in_l(sl4), .ser_in_r(sr4), .load_data(ld4),
        .data_out(d4), .ser_out(so4), .bit_cnt(cnt4), .frame_done(fd4)
    );

    univ_shift_reg #(.WIDTH(8)) u8 (
        .clk(clk), .rstn(rstn8), .en(en8), .mode(mode8),
        .ser_in_l(sl8), .ser_in_r(sr8), .load_data(ld8),
        .data_out(d8), .ser_out(so8), .bit_cnt(cnt8), .frame_done(fd8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] d, input logic so,
                        input logic [1:0] cnt, input logic fd);
        check({tag, ".d4"},   64'(d4),   64'(d));
        check({tag, ".so4"},  64'(so4),  64'(so));
        check({tag, ".cnt4"}, 64'(cnt4), 64'(cnt));
        check({tag, ".fd4"},  64'(fd4),  64'(fd));
    endtask

    task automatic chk8(input string tag, input logic [7:0] d, input logic so,
                        input logic [2:0] cnt, input logic fd);
        check({tag, ".d8"},   64'(d8),   64'(d));
        check({tag, ".so8"},  64'(so8),  64'(so));
        check({tag, ".cnt8"}, 64'(cnt8), 64'(cnt));
        check({tag, ".fd8"},  64'(fd8),  64'(fd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ser_exp;
        ser_exp = 8'hA5;

        // Test 1: reset overrides an active shift, then en=0 holds
        rstn4 = 1'b0; en4 = 1'b1; mode4 = 3'b001; sl4 = 1'b1; sr4 = 1'b0; ld4 = 4'h0;
        rstn8 = 1'b0; en8 = 1'b1; mode8 = 3'b001; sl8 = 1'b1; sr8 = 1'b0; ld8 = 8'h00;
        tick(); chk4("t1_rst_a", 4'h0, 1'b0, 2'd0, 1'b0);
        tick(); chk4("t1_rst_b", 4'h0, 1'b0, 2'd0, 1'b0);
        chk8("t1_rst8", 8'h00, 1'b0, 3'd0, 1'b0);
        rstn4 = 1'b1; en4 = 1'b0;
        rstn8 = 1'b1; en8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk4($sformatf("t1_hold%0d", i), 4'h0, 1'b0, 2'd0, 1'b0);
        end

        // Test 2: legacy SHL 1,0,1,1
        en4 = 1'b1; mode4 = 3'b001;
        sl4 = 1'b1; tick(); chk4("t2_s1", 4'b0001, 1'b0, 2'd1, 1'b0);
        sl4 = 1'b0; tick(); chk4("t2_s2", 4'b0010, 1'b0, 2'd2, 1'b0);
        sl4 = 1'b1; tick(); chk4("t2_s3", 4'b0101, 1'b0, 2'd3, 1'b0);
        sl4 = 1'b1; tick(); chk4("t2_s4", 4'b1011, 1'b0, 2'd0, 1'b1);
        mode4 = 3'b000; tick(); chk4("t2_hold", 4'b1011, 1'b0, 2'd0, 1'b0);

        // Test 3: load + rotate/arith on WIDTH=8
        en8 = 1'b1;
        mode8 = 3'b110; ld8 = 8'h96; tick(); chk8("t3_load", 8'h96, 1'b0, 3'd0, 1'b0);
        mode8 = 3'b011; tick(); chk8("t3_rol", 8'h2D, 1'b1, 3'd1, 1'b0);
        mode8 = 3'b100; tick(); chk8("t3_ror", 8'h96, 1'b1, 3'd2, 1'b0);
        mode8 = 3'b101; sr8 = 1'b0; tick(); chk8("t3_asr", 8'hCB, 1'b0, 3'd3, 1'b0);
        mode8 = 3'b010; sr8 = 1'b0; tick(); chk8("t3_shr", 8'h65, 1'b1, 3'd4, 1'b0);

        // Test 4: serializer frame of 0xA5
        mode8 = 3'b110; ld8 = 8'hA5; tick(); chk8("t4_load", 8'hA5, 1'b1, 3'd0, 1'b0);
        mode8 = 3'b001; sl8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t4_so%0d", i), 64'(so8), 64'(ser_exp[7-i]));
            check($sformatf("t4_fd%0d", i), 64'(fd8), 64'(i == 7));
        end
        check("t4_data", 64'(d8), 64'h00);
        check("t4_cnt", 64'(cnt8), 64'd0);
        mode8 = 3'b000; tick(); check("t4_fd_after", 64'(fd8), 64'd0);

        // Test 5: LOAD on the would-wrap cycle suppresses the pulse
        mode4 = 3'b010; sr4 = 1'b0;
        tick(); chk4("t5_shr1", 4'b0101, 1'b1, 2'd1, 1'b0);
        tick(); chk4("t5_shr2", 4'b0010, 1'b1, 2'd2, 1'b0);
        tick(); chk4("t5_shr3", 4'b0001, 1'b0, 2'd3, 1'b0);
        mode4 = 3'b110; ld4 = 4'hF;
        tick(); chk4("t5_load", 4'hF, 1'b0, 2'd0, 1'b0);
        mode4 = 3'b010; sr4 = 1'b1;
        tick(); chk4("t5_a", 4'hF, 1'b1, 2'd1, 1'b0);
        tick(); chk4("t5_b", 4'hF, 1'b1, 2'd2, 1'b0);
        tick(); chk4("t5_c", 4'hF, 1'b1, 2'd3, 1'b0);
        tick(); chk4("t5_d", 4'hF, 1'b1, 2'd0, 1'b1);

        // Test 6: mid-frame reset, then CLEAR on the would-wrap cycle
        mode4 = 3'b001; sl4 = 1'b0;
        tick(); chk4("t6_s1", 4'b1110, 1'b1, 2'd1, 1'b0);
        tick(); chk4("t6_s2", 4'b1100, 1'b1, 2'd2, 1'b0);
        rstn4 = 1'b0;
        tick(); chk4("t6_rst", 4'h0, 1'b0, 2'd0, 1'b0);
        rstn4 = 1'b1; sl4 = 1'b1;
        tick(); chk4("t6_p1", 4'b0001, 1'b0, 2'd1, 1'b0);
        tick(); chk4("t6_p2", 4'b0011, 1'b0, 2'd2, 1'b0);
        tick(); chk4("t6_p3", 4'b0111, 1'b0, 2'd3, 1'b0);
        mode4 = 3'b111;
        tick(); chk4("t6_clr", 4'h0, 1'b0, 2'd0, 1'b0);
        mode4 = 3'b001;
        tick(); chk4("t6_q1", 4'b0001, 1'b0, 2'd1, 1'b0);
        tick(); chk4("t6_q2", 4'b0011, 1'b0, 2'd2, 1'b0);
        tick(); chk4("t6_q3", 4'b0111, 1'b0, 2'd3, 1'b0);
        tick(); chk4("t6_q4", 4'b1111, 1'b0, 2'd0, 1'b1);
        en4 = 1'b0; sl4 = 1'b0;
        tick(); chk4("t6_en0", 4'b1111, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It is the next generation of the team's 4-bit serial-in left shifter.
- Adds configurable width, bidirectional shift, rotate, arithmetic shift right, parallel load and synchronous clear.
- Provides a registered serial output and a frame counter that pulses after every WIDTH shift operations.
- Used as a serializer/deserializer building block and for bit-manipulation datapaths.

Parameters:
WIDTH, 4, register width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), local parameter (not overridable); width of bit_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  synchronous active-low reset
en  input  1  operation enable; when 0, all state holds
mode  input  3  operation select, sampled when en=1
ser_in_l  input  1  bit entering the LSB on shift-left
ser_in_r  input  1  bit entering the MSB on logical shift-right
load_data  input  WIDTH  parallel load value
data_out  output  WIDTH  register contents
ser_out  output  1  last bit shifted or rotated out, registered
bit_cnt  output  CNT_W  shift operations since last frame boundary/load/clear
frame_done  output  1  one-cycle pulse marking a completed frame of WIDTH shifts

Behaviour:
- One clock domain, one clock.
- Reset is synchronous and active-low: at a rising clk edge with rstn=0, data_out=0, ser_out=0, bit_cnt=0, frame_done=0. Reset overrides en and mode.
- All outputs are registered; the effect of an operation is visible one cycle after the sampling edge.
- en=0: data_out, ser_out and bit_cnt hold; frame_done=0.
- mode encodings (with en=1; D = data_out, W = WIDTH):
  - 000 HOLD: no change. frame_done=0.
  - 001 SHL: D <= {D[W-2:0], ser_in_l}; ser_out <= D[W-1].
  - 010 SHR: D <= {ser_in_r, D[W-1:1]}; ser_out <= D[0].
  - 011 ROL: D <= {D[W-2:0], D[W-1]}; ser_out <= D[W-1].
  - 100 ROR: D <= {D[0], D[W-1:1]}; ser_out <= D[0].
  - 101 ASR: D <= {D[W-1], D[W-1:1]}; sign bit replicated, ser_in_r ignored; ser_out <= D[0].
  - 110 LOAD: D <= load_data; bit_cnt <= 0; ser_out holds.
  - 111 CLEAR: D <= 0; bit_cnt <= 0; ser_out <= 0.
- Shift operations are modes 001–101 (SHL, SHR, ROL, ROR, ASR).
- Frame counter:
  - Each shift operation increments bit_cnt.
  - If bit_cnt == W-1 when a shift is applied: bit_cnt wraps to 0 and frame_done=1 in the following cycle.
  - frame_done is 1 for exactly one cycle per wrap. Back-to-back frames give a pulse every W shift cycles.
  - frame_done=0 in every cycle not following a wrap, including after HOLD, LOAD, CLEAR or en=0.
  - Mixed shift modes within one frame all count.
  - If W is not a power of two, bit_cnt still wraps at W-1, never at 2^CNT_W-1.
- Boundary cases:
  - Reset asserted mid-frame discards partial count and data; no frame_done pulse.
  - LOAD or CLEAR on the cycle that would have wrapped: no pulse, bit_cnt=0.
  - Inputs (mode, ser_in_l, ser_in_r, load_data) are only sampled when en=1.
- No combinational path from any input to any output.

Test Plan:
1. Reset/hold: WIDTH=4, apply rstn=0 for 2 cycles with en=1, mode=001, ser_in_l=1 -> data_out=0000, ser_out=0, bit_cnt=0, frame_done=0. Then en=0 for 3 cycles -> all outputs unchanged.
2. Legacy-equivalent SHL: WIDTH=4, mode=001, ser_in_l sequence 1,0,1,1 -> data_out 0001, 0010, 0101, 1011. frame_done=1 only in the cycle after the 4th shift, with bit_cnt=0.
3. Load + rotate/arith: WIDTH=8, LOAD 0x96 -> 0x96. Then:
   - ROL -> 0x2D, ser_out=1.
   - ROR -> 0x96, ser_out=1.
   - ASR -> 0xCB, ser_out=0.
   - SHR with ser_in_r=0 -> 0x65, ser_out=1.
4. Serializer frame: WIDTH=8, LOAD 0xA5, then 8 consecutive SHL with ser_in_l=0 -> ser_out sequence 1,0,1,0,0,1,0,1. frame_done pulses once after the 8th shift; data_out=0x00.
5. Frame interruption: WIDTH=4, perform 3 SHR, then LOAD 0xF on the 4th cycle -> no frame_done, bit_cnt=0, data_out=1111. Perform 4 more SHR -> exactly one frame_done pulse.
6. Mid-frame reset and CLEAR: WIDTH=4, 2 shifts then rstn=0 for one cycle -> bit_cnt=0, data_out=0. Then 3 shifts and CLEAR -> bit_cnt=0, ser_out=0, no pulse. Then 4 more shifts -> exactly one frame_done pulse.
